// File: rtl/lc_dco_capbank_ctrl_if.sv
// Tuning-code handshake between frequency control and the cap-bank sequencer.
interface lc_dco_capbank_ctrl_if #(
  parameter int CW        = 4,
  parameter int FINE_BITS = 4
);
  logic                 code_valid;
  logic                 code_ready;
  logic [CW-1:0]        code_coarse;
  logic [FINE_BITS-1:0] code_fine;

  modport master (
    output code_valid,
    output code_coarse,
    output code_fine,
    input  code_ready
  );

  modport slave (
    input  code_valid,
    input  code_coarse,
    input  code_fine,
    output code_ready
  );
endinterface

// File: rtl/lc_dco_capbank_ctrl.sv
// LC DCO cap-bank sequencer: thermometer coarse ramp with settle gaps,
// then a single glitch-free fine-bank update.
module lc_dco_capbank_ctrl #(
  parameter int NCOARSE    = 8,
  parameter int FINE_BITS  = 4,
  parameter int SETTLE     = 4,
  parameter int RST_COARSE = NCOARSE / 2,
  localparam int CW        = $clog2(NCOARSE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  lc_dco_capbank_ctrl_if.slave code_if,
  input  logic                 freeze,
  output logic [NCOARSE-1:0]   sw_coarse,
  output logic [FINE_BITS-1:0] sw_fine,
  output logic                 busy,
  output logic                 done,
  output logic                 sat
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_FINE = 2'd3;

  localparam logic [CW-1:0] NMAX    = CW'(NCOARSE);
  localparam logic [CW-1:0] RST_CNT = CW'(RST_COARSE);
  localparam logic [SW-1:0] SET_LD  = SW'(SETTLE - 1);

  function automatic logic [NCOARSE-1:0] therm(
    input logic [CW-1:0] n
  );
    logic [NCOARSE-1:0] t;
    for (int i = 0; i < NCOARSE; i++) begin
      t[i] = (int'(n) > i);
    end
    return t;
  endfunction

  localparam logic [NCOARSE-1:0] RST_TH = therm(RST_CNT);

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        tgt_q, tgt_d;
  logic [FINE_BITS-1:0] fine_tgt_q, fine_tgt_d;
  logic                 sat_r_q, sat_r_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic [NCOARSE-1:0]   sw_coarse_q, sw_coarse_d;
  logic [FINE_BITS-1:0] sw_fine_q, sw_fine_d;
  logic                 done_q, done_d;
  logic                 sat_q, sat_d;
  logic [CW-1:0]        clamp;

  assign clamp = (code_if.code_coarse > NMAX) ? NMAX
               : code_if.code_coarse;

  // Frozen cycles make no progress; done/sat stay low so no pulse is lost
  // or stretched, the FINE edge simply fires once freeze drops.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tgt_d      = tgt_q;
    fine_tgt_d = fine_tgt_q;
    sat_r_d    = sat_r_q;
    settle_d   = settle_q;
    sw_fine_d  = sw_fine_q;
    done_d     = 1'b0;
    sat_d      = 1'b0;
    if (!freeze) begin
      unique case (state_q)
        S_IDLE: begin
          if (code_if.code_valid) begin
            tgt_d      = clamp;
            fine_tgt_d = code_if.code_fine;
            sat_r_d    = (code_if.code_coarse > NMAX);
            state_d    = (clamp != count_q) ? S_STEP : S_FINE;
          end
        end
        S_STEP: begin
          count_d  = (tgt_q > count_q) ? count_q + CW'(1)
                                       : count_q - CW'(1);
          settle_d = SET_LD;
          state_d  = S_WAIT;
        end
        S_WAIT: begin
          if (settle_q == '0) begin
            state_d = (count_q != tgt_q) ? S_STEP : S_FINE;
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end
        S_FINE: begin
          sw_fine_d = fine_tgt_q;
          done_d    = 1'b1;
          sat_d     = sat_r_q;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    sw_coarse_d = therm(count_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= RST_CNT;
      tgt_q       <= RST_CNT;
      fine_tgt_q  <= '0;
      sat_r_q     <= 1'b0;
      settle_q    <= '0;
      sw_coarse_q <= RST_TH;
      sw_fine_q   <= '0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      tgt_q       <= tgt_d;
      fine_tgt_q  <= fine_tgt_d;
      sat_r_q     <= sat_r_d;
      settle_q    <= settle_d;
      sw_coarse_q <= sw_coarse_d;
      sw_fine_q   <= sw_fine_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
    end
  end

  assign code_if.code_ready = (state_q == S_IDLE) && !freeze;
  assign sw_coarse          = sw_coarse_q;
  assign sw_fine            = sw_fine_q;
  assign busy               = (state_q != S_IDLE);
  assign done               = done_q;
  assign sat                = sat_q;

endmodule

// File: tb/tb_lc_dco_capbank_ctrl.sv
// Scoreboard bench for lc_dco_capbank_ctrl: directed codes, expected
// coarse steps and done events queued at issue, checked by a monitor.
module tb_lc_dco_capbank_ctrl;

  localparam int NC = 8;
  localparam int FB = 4;
  localparam int ST = 4;
  localparam int RC = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze;
  logic [NC-1:0] sw_coarse;
  logic [FB-1:0] sw_fine;
  logic          busy, done, sat;

  always #5 clk = ~clk;

  lc_dco_capbank_ctrl_if #(.CW(CW), .FINE_BITS(FB)) cif ();

  lc_dco_capbank_ctrl #(
    .NCOARSE(NC), .FINE_BITS(FB), .SETTLE(ST), .RST_COARSE(RC)
  ) dut (
    .clk(clk), .rst(rst), .code_if(cif.slave), .freeze(freeze),
    .sw_coarse(sw_coarse), .sw_fine(sw_fine),
    .busy(busy), .done(done), .sat(sat)
  );

  typedef struct {
    int            t;
    logic [NC-1:0] v;
  } cev_t;

  typedef struct {
    int            t;
    logic [FB-1:0] fine;
    logic          sat;
    logic [NC-1:0] coarse;
  } dev_t;

  cev_t cq[$];
  dev_t dq[$];
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
               nm, act, act, exp, exp, cyc);
    end
  endfunction

  function automatic void push_c(int t, logic [NC-1:0] v);
    cev_t e;
    e.t = t; e.v = v;
    cq.push_back(e);
  endfunction

  function automatic void push_d(int t, logic [FB-1:0] f, logic s,
                                 logic [NC-1:0] c);
    dev_t e;
    e.t = t; e.fine = f; e.sat = s; e.coarse = c;
    dq.push_back(e);
  endfunction

  // Monitor: pops an expectation on every sw_coarse change and every done.
  initial begin : monitor
    logic [NC-1:0] prev;
    cev_t ce;
    dev_t de;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = sw_coarse;
      end else begin
        if (sw_coarse !== prev) begin
          if (cq.size() == 0) begin
            checks++; errs++;
            $display("FAIL coarse_unexpected: got 0x%0h was 0x%0h cyc %0d",
                     sw_coarse, prev, cyc);
          end else begin
            ce = cq.pop_front();
            chk("coarse_val", int'(sw_coarse), int'(ce.v));
            chk("coarse_time", cyc, ce.t);
          end
          prev = sw_coarse;
        end
        if (done) begin
          if (dq.size() == 0) begin
            checks++; errs++;
            $display("FAIL done_unexpected: got done=1 expected none cyc %0d",
                     cyc);
          end else begin
            de = dq.pop_front();
            chk("done_time", cyc, de.t);
            chk("done_fine", int'(sw_fine), int'(de.fine));
            chk("done_sat", int'(sat), int'(de.sat));
            chk("done_coarse", int'(sw_coarse), int'(de.coarse));
            chk("done_ready", int'(cif.code_ready), 1);
          end
        end
      end
    end
  end

  task automatic to_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic accept(input logic [CW-1:0] c, input logic [FB-1:0] f,
                        output int e0);
    int n = 0;
    while (!cif.code_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", int'(cif.code_ready), 1);
    cif.code_valid  = 1'b1;
    cif.code_coarse = c;
    cif.code_fine   = f;
    e0 = cyc + 1;
    @(negedge clk);
    cif.code_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((cq.size() != 0 || dq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cq.size() != 0 || dq.size() != 0) begin
      errs++;
      $display("FAIL %s_timeout: pending coarse=%0d done=%0d expected 0",
               nm, cq.size(), dq.size());
      cq.delete();
      dq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_coarse", int'(sw_coarse), 'h0F);
    chk("rst_fine", int'(sw_fine), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    int e0;
    logic [NC-1:0] snap;
    rst = 1'b1;
    freeze = 1'b0;
    cif.code_valid  = 1'b0;
    cif.code_coarse = '0;
    cif.code_fine   = '0;
    repeat (2) @(negedge clk);
    chk("init_coarse", int'(sw_coarse), 'h0F);
    chk("init_fine", int'(sw_fine), 0);
    chk("init_ready", int'(cif.code_ready), 1);
    chk("init_busy", int'(busy), 0);
    chk("init_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Two-step ramp up
    accept(4'd6, 4'd5, e0);
    push_c(e0 + 1, 8'h1F);
    push_c(e0 + 6, 8'h3F);
    push_d(e0 + 11, 4'd5, 1'b0, 8'h3F);
    to_cyc(e0 + 1);
    chk("busy_first", int'(busy), 1);
    chk("ready_busy", int'(cif.code_ready), 0);
    to_cyc(e0 + 10);
    chk("busy_last", int'(busy), 1);
    to_cyc(e0 + 11);
    chk("busy_end", int'(busy), 0);
    drain("ramp_up");

    // No coarse change, then ramp to zero
    do_reset();
    accept(4'd4, 4'd9, e0);
    push_d(e0 + 1, 4'd9, 1'b0, 8'h0F);
    drain("d0");
    accept(4'd0, 4'd3, e0);
    push_c(e0 + 1, 8'h07);
    push_c(e0 + 6, 8'h03);
    push_c(e0 + 11, 8'h01);
    push_c(e0 + 16, 8'h00);
    push_d(e0 + 21, 4'd3, 1'b0, 8'h00);
    drain("ramp_down");

    // Clamped code, with a stray code_valid while busy
    do_reset();
    accept(4'd12, 4'd6, e0);
    push_c(e0 + 1, 8'h1F);
    push_c(e0 + 6, 8'h3F);
    push_c(e0 + 11, 8'h7F);
    push_c(e0 + 16, 8'hFF);
    push_d(e0 + 21, 4'd6, 1'b1, 8'hFF);
    to_cyc(e0 + 4);
    cif.code_valid  = 1'b1;
    cif.code_coarse = 4'd2;
    cif.code_fine   = 4'd15;
    @(negedge clk);
    cif.code_valid = 1'b0;
    drain("clamp");

    // Freeze for 10 edges mid-ramp
    do_reset();
    accept(4'd6, 4'd10, e0);
    push_c(e0 + 1, 8'h1F);
    push_c(e0 + 16, 8'h3F);
    push_d(e0 + 21, 4'd10, 1'b0, 8'h3F);
    to_cyc(e0 + 2);
    freeze = 1'b1;
    snap = sw_coarse;
    repeat (10) begin
      @(negedge clk);
      chk("frz_ready", int'(cif.code_ready), 0);
      chk("frz_coarse", int'(sw_coarse), int'(snap));
      chk("frz_done", int'(done), 0);
    end
    freeze = 1'b0;
    drain("freeze");

    // Async reset mid-ramp, then a normal update
    accept(4'd8, 4'd1, e0);
    push_c(e0 + 1, 8'h7F);
    push_c(e0 + 6, 8'hFF);
    to_cyc(e0 + 6);
    #1 rst = 1'b1;
    #1;
    chk("arst_coarse", int'(sw_coarse), 'h0F);
    chk("arst_fine", int'(sw_fine), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("arst_no_pending", cq.size() + dq.size(), 0);
    accept(4'd5, 4'd2, e0);
    push_c(e0 + 1, 8'h1F);
    push_d(e0 + 6, 4'd2, 1'b0, 8'h1F);
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/lc_dco_capbank_ctrl.md
# lc_dco_capbank_ctrl

Digital sequencer for the LC DCO switched-capacitor tuning banks, generalised to a parametrised thermometer-coded coarse bank plus a binary-weighted fine bank. It accepts a tuning code over a valid/ready handshake and drives the bank switch lines glitch-free. The coarse bank ramps one element at a time, with a programmable settle interval between steps, so the oscillator never sees a large frequency jump. It sits between the frequency-control logic and the `sw` inputs of the LC DCO top, one instance per oscillator.

## Interface
- NCOARSE, 8: number of unit coarse swcap cells (thermometer); ≥2
- FINE_BITS, 4: width of the binary-weighted fine bank; ≥1
- SETTLE, 4: settle cycles after each coarse step; ≥1
- RST_COARSE, NCOARSE/2: coarse count after reset; ≤NCOARSE
- CW (local), $clog2(NCOARSE+1): coarse code width
- clk  input  1  single clock
- rst  input  1  reset, asynchronous, active-high
- code_valid  input  1  new code offered
- code_ready  output  1  block accepts code this cycle
- code_coarse  input  CW  target number of enabled coarse cells
- code_fine  input  FINE_BITS  target fine word
- freeze  input  1  hold all progress while high
- sw_coarse  output  NCOARSE  thermometer switch lines, bit i = (count > i)
- sw_fine  output  FINE_BITS  fine bank switch lines
- busy  output  1  ramp/update in progress
- done  output  1  one-cycle pulse, update complete
- sat  output  1  valid with done; accepted coarse code was clamped

## Operation
- States: IDLE, STEP, WAIT, FINE.
- code_ready = (state==IDLE) && !freeze. Handshake completes on a clock edge with code_valid && code_ready. code_valid is ignored at all other times, including while busy.
- On accept:
  - Latch tgt = min(code_coarse, NCOARSE) and the fine word.
  - Latch sat_r = (code_coarse > NCOARSE).
  - Go to STEP if tgt ≠ count, otherwise go to FINE.
- STEP: count ← count ± 1 toward tgt. sw_coarse updates on the same edge. Load the settle counter with SETTLE-1 and go to WAIT.
- WAIT: decrement the settle counter. On the edge where the counter is 0, go to STEP if count ≠ tgt, otherwise go to FINE.
- FINE: sw_fine ← latched fine word. done ← 1 and sat ← sat_r for exactly one cycle. Go to IDLE.
- At most one sw_coarse bit changes per edge. sw_fine changes only in FINE, after the coarse ramp has finished.
- freeze=1:
  - State, count, settle counter and all outputs hold.
  - done is not emitted while frozen. A FINE edge that would have fired is deferred until freeze drops.
- busy = (state ≠ IDLE).
- Reset values, applied asynchronously, including mid-ramp:
  - state IDLE, count RST_COARSE, sw_coarse = thermometer(RST_COARSE)
  - sw_fine 0, busy 0, done 0, sat 0, code_ready 1 (if freeze=0)
  - latched target discarded

## Timing
- Let E0 be the accept edge and d = |tgt − count at E0|.
- Coarse step k (1..d) appears on sw_coarse at edge E0 + 1 + (k−1)(1+SETTLE).
- done, sat and the new sw_fine appear at edge E0 + d(1+SETTLE) + 1. For d=0 this is E0+1.
- code_ready rises on the same edge as done, so a back-to-back accept is possible on the next edge.
- freeze held high for F cycles while busy delays every later event by exactly F cycles.
- All outputs are registered; no combinational path from inputs to sw_*.

## Test plan
- Use NCOARSE=8, FINE_BITS=4, SETTLE=4 and RST_COARSE=4 throughout.
- Reset: sw_coarse=0x0F, sw_fine=0, code_ready=1, busy=0, done=0.
- Accept coarse=6, fine=5 at E0 -> sw_coarse=0x1F at E0+1 and 0x3F at E0+6; done=1 with sw_fine=5 and sat=0 at E0+11; busy high E0+1..E0+10.
- From reset, accept coarse=4, fine=9 -> sw_coarse stays 0x0F; sw_fine=9 and done at E0+1. Then accept coarse=0 -> sw_coarse steps 0x07, 0x03, 0x01, 0x00 at E0+1, +6, +11, +16; done at E0+21.
- Accept coarse=12 -> clamped to 8; sw_coarse reaches 0xFF at E0+16; done with sat=1 at E0+21. Pulsing code_valid while busy has no effect.
- Accept coarse=6 -> hold freeze high for 10 cycles starting at E0+3: all outputs held, code_ready=0, and done moves to E0+21.
- Accept coarse=8 -> assert rst at E0+7: sw_coarse=0x0F and sw_fine=0 immediately, without waiting for a clock edge; no done pulse. After release, a new accept proceeds normally.
